pipelined_cla_subtractor: RTL and testbench
===========================================

// Module: pipelined_cla_subtractor
// PURPOSE
//  Pipelined carry-lookahead subtractor: diff = a - b - bborrow_in, processed STAGE_WIDTH bits per stage.
//  Lookahead borrow inside each stage; registered borrow passed between stages.
//  Valid/ready on both sides. One result per cycle at full throughput.
//  Companion to the combinational CLA adder in the arithmetic-circuits library.
// PARAMETERS
//  WIDTH        16  operand/result width; must be a multiple of STAGE_WIDTH
//  STAGE_WIDTH  4   bits resolved per pipeline stage; NUM_STAGES = WIDTH/STAGE_WIDTH (derived localparam)
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat offered
//  in_ready   out  1      block accepts beat when in_valid & in_ready
//  a          in   WIDTH  minuend (unsigned or two's complement)
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      result beat offered
//  out_ready  in   1      downstream accepts when out_valid & out_ready
//  diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//  bout       out  1      unsigned borrow out: 1 iff a < b + bin
//  ovf        out  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
// BEHAVIOUR
//  - Reset (async assert): all stage valid bits 0; out_valid=0, diff=0, bout=0, ovf=0. in_ready=1 after reset.
//  - Per-bit lookahead: g_i = ~a_i & b_i, p_i = ~(a_i ^ b_i); borrow_{i+1} = g_i | (p_i & borrow_i); d_i = a_i ^ b_i ^ borrow_i.
//  - Stage k (0..NUM_STAGES-1) computes bits [k*SW +: SW] from its registered borrow; stage 0 uses bin.
//  - Upper operand slices and already-computed lower diff slices travel with the beat; no recomputation.
//  - ovf computed in final stage from carried a[MSB], b[MSB] and the final diff[MSB].
//  - Latency: accepted beat appears on out_valid exactly NUM_STAGES cycles later when out_ready held 1.
//  - Stage advance: stage k loads from k-1 when stage k is empty or stage k hands on in the same cycle.
//  - Last stage hands on iff out_valid & out_ready. in_ready = ~v0 | stage0 advances (combinational on out_ready).
//  - Backpressure: out_ready=0 holds diff/bout/ovf/out_valid stable; bubbles collapse; stall lasts until all stages full.
//  - Max occupancy NUM_STAGES beats; no beat dropped or duplicated; strict in-order delivery.
//  - Simultaneous accept + emit with a full pipe: both happen; occupancy unchanged.
//  - Outputs hold their last value when out_valid=0 (don't-care for checking, no X).
//  - Reset mid-operation: all in-flight beats discarded; no partial result emitted afterwards.
//  - Inputs sampled only on accept; a/b/bin changes while in_ready=0 have no effect.
// TESTING
//  1 a=0x0005,b=0x0003,bin=0, out_ready=1 -> 4 cycles later diff=0x0002,bout=0,ovf=0.
//  2 a=0x0000,b=0x0001,bin=0 -> diff=0xFFFF,bout=1,ovf=0; a=0x0000,b=0xFFFF,bin=1 -> diff=0x0000,bout=1.
//  3 a=0x8000,b=0x0001 -> diff=0x7FFF,bout=0,ovf=1; a=0x7FFF,b=0xFFFF -> diff=0x8000,bout=1,ovf=1.
//  4 Stream 8 beats back-to-back, out_ready=0 for cycles 2..7 -> in_ready falls after 4 held beats; all 8 emerge in order, none lost.
//  5 rst pulse with 3 beats in flight -> out_valid=0 from assertion; no stale beats after release; next beat latency=4.
//  6 10k random beats, random in_valid/out_ready -> every result matches {bout,diff} = {1'b0,a} - b - bin; ovf matches model.

Source files
------------

// File: rtl/pipelined_cla_subtractor.sv
// Pipelined CLA subtractor: one STAGE_WIDTH slice of a - b - bin per stage, NUM_STAGES cycles accept-to-out_valid.
// Valid/ready both sides; stalled stages hold while empty stages ahead of them keep filling, so bubbles collapse.
module pipelined_cla_subtractor #(
  parameter int WIDTH       = 16,
  parameter int STAGE_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NUM_STAGES = WIDTH / STAGE_WIDTH;

  // Operands travel whole; each stage only reads its own slice of them.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             brw;
  } beat_t;

  beat_t                 st_q    [NUM_STAGES];
  beat_t                 st_d    [NUM_STAGES];
  beat_t                 src     [NUM_STAGES];
  beat_t                 nxt     [NUM_STAGES];
  logic [STAGE_WIDTH:0]  slc     [NUM_STAGES];
  logic [NUM_STAGES-1:0] src_vld;
  logic [NUM_STAGES-1:0] v_q, v_d, ld;
  logic                  ovf_q, ovf_d;

  function automatic logic [STAGE_WIDTH:0] sub_slice(
    input logic [STAGE_WIDTH-1:0] x,
    input logic [STAGE_WIDTH-1:0] y,
    input logic                   bi
  );
    logic [STAGE_WIDTH-1:0] g, p, d;
    logic [STAGE_WIDTH:0]   br;
    g     = ~x & y;
    p     = ~(x ^ y);
    br    = '0;
    d     = '0;
    br[0] = bi;
    for (int i = 0; i < STAGE_WIDTH; i++) begin
      br[i+1] = g[i] | (p[i] & br[i]);
      d[i]    = x[i] ^ y[i] ^ br[i];
    end
    return {br[STAGE_WIDTH], d};
  endfunction

  always_comb begin
    // A stage can load when it is empty or everything ahead of it moves this cycle.
    ld[NUM_STAGES-1] = ~v_q[NUM_STAGES-1] | out_ready;
    for (int k = NUM_STAGES - 2; k >= 0; k--) begin
      ld[k] = ~v_q[k] | ld[k+1];
    end

    src_vld[0]  = in_valid;
    src[0].a    = a;
    src[0].b    = b;
    src[0].diff = '0;
    src[0].brw  = bin;
    for (int k = 1; k < NUM_STAGES; k++) begin
      src_vld[k] = v_q[k-1];
      src[k]     = st_q[k-1];
    end

    ovf_d = ovf_q;
    for (int k = 0; k < NUM_STAGES; k++) begin
      slc[k] = sub_slice(src[k].a[k*STAGE_WIDTH +: STAGE_WIDTH],
                         src[k].b[k*STAGE_WIDTH +: STAGE_WIDTH],
                         src[k].brw);
      nxt[k] = src[k];
      nxt[k].diff[k*STAGE_WIDTH +: STAGE_WIDTH] = slc[k][STAGE_WIDTH-1:0];
      nxt[k].brw = slc[k][STAGE_WIDTH];
      v_d[k]  = ld[k] ? src_vld[k] : v_q[k];
      st_d[k] = (ld[k] && src_vld[k]) ? nxt[k] : st_q[k];
    end

    if (ld[NUM_STAGES-1] && src_vld[NUM_STAGES-1]) begin
      ovf_d = (nxt[NUM_STAGES-1].a[WIDTH-1] ^ nxt[NUM_STAGES-1].b[WIDTH-1]) &
              (nxt[NUM_STAGES-1].diff[WIDTH-1] ^ nxt[NUM_STAGES-1].a[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < NUM_STAGES; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v_q[NUM_STAGES-1];
  assign diff      = st_q[NUM_STAGES-1].diff;
  assign bout      = st_q[NUM_STAGES-1].brw;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Bench for pipelined_cla_subtractor: directed corner beats, backpressure, reset flush, random streaming
// checked against an arithmetic reference model and an in-order expectation queue.
module tb_pipelined_cla_subtractor;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int          checks = 0;
  int          miscompares = 0;
  logic [17:0] exp_q[$];
  bit          sb_on = 1'b0;
  bit          hold_prev = 1'b0;
  bit          acc = 1'b0;
  logic [17:0] prev = '0;
  int          n_out = 0;
  int          sent = 0;
  int          first_stall = -1;
  int          stale = 0;
  logic [W-1:0] va [8];
  logic [W-1:0] vb [8];
  logic         vbin [8];
  logic [W-1:0] ra, rb;
  logic         rbin;

  pipelined_cla_subtractor #(.WIDTH(16), .STAGE_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: {bout, ovf, diff} from plain 17-bit arithmetic.
  function automatic logic [17:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    logic [16:0] r;
    logic        o;
    r = {1'b0, x} - {1'b0, y} - {16'd0, bi};
    o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    return {r[16], o, r[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  // Called at the falling edge: scoreboard emit/accept and hold-under-backpressure.
  task automatic sample();
    acc = in_valid && in_ready;
    if (sb_on) begin
      if (hold_prev) chk("hold", {13'd0, out_valid, bout, ovf, diff}, {13'd0, 1'b1, prev});
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL spurious: got out beat with %0d pending, expected none", exp_q.size());
        end
        if (exp_q.size() != 0) begin
          chk("result", {14'd0, bout, ovf, diff}, {14'd0, exp_q.pop_front()});
          n_out++;
        end
      end
      hold_prev = out_valid && !out_ready;
      prev      = {bout, ovf, diff};
      if (acc) exp_q.push_back(model(a, b, bin));
    end
  endtask

  task automatic one_beat(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                          input logic [17:0] want);
    int lat;
    int nv;
    in_valid = 1'b1; a = ta; b = tb_; bin = tbin; out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    lat = 0;
    nv  = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        nv++;
        if (lat == 0) begin
          lat = i;
          chk("beat", {14'd0, bout, ovf, diff}, {14'd0, want});
        end
      end
      @(posedge clk); #1;
    end
    chk("latency", lat, 4);
    chk("single_emit", nv, 1);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_diff", {16'd0, diff}, 0);
    chk("rst_bout_ovf", {30'd0, bout, ovf}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk); #1;

    // Directed corner beats
    one_beat(16'h0005, 16'h0003, 1'b0, {1'b0, 1'b0, 16'h0002});
    one_beat(16'h0000, 16'h0001, 1'b0, {1'b1, 1'b0, 16'hFFFF});
    one_beat(16'h0000, 16'hFFFF, 1'b1, {1'b1, 1'b0, 16'h0000});
    one_beat(16'h8000, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h7FFF});
    one_beat(16'h7FFF, 16'hFFFF, 1'b0, {1'b1, 1'b1, 16'h8000});

    // Eight back-to-back beats, downstream stalled for cycles 2..7
    for (int i = 0; i < 8; i++) begin
      va[i] = W'($urandom); vb[i] = W'($urandom); vbin[i] = 1'($urandom);
    end
    sb_on = 1'b1; hold_prev = 1'b0; n_out = 0; sent = 0; first_stall = -1;
    for (int r = 0; r < 40; r++) begin
      out_ready = !(r >= 2 && r <= 7);
      if (sent < 8) begin
        in_valid = 1'b1; a = va[sent]; b = vb[sent]; bin = vbin[sent];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (!in_ready && first_stall < 0) first_stall = sent;
      sample();
      if (acc) sent++;
      @(posedge clk); #1;
    end
    chk("stall_after", first_stall, 4);
    chk("stream_count", n_out, 8);
    chk("stream_drain", exp_q.size(), 0);

    // Reset with three beats in flight
    sb_on = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("inflight_valid", {31'd0, out_valid}, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_flush", {31'd0, out_valid}, 0);
    exp_q.delete();
    repeat (2) begin @(posedge clk); end
    #1 rst = 1'b0; out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    chk("no_stale", stale, 0);
    ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
    one_beat(ra, rb, rbin, model(ra, rb, rbin));

    // Random streaming with random valid and ready
    sb_on = 1'b1; hold_prev = 1'b0; n_out = 0; sent = 0;
    for (int r = 0; r < 60000 && (sent < 10000 || exp_q.size() != 0); r++) begin
      in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      bin       = 1'($urandom);
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      sample();
      if (acc) sent++;
      @(posedge clk); #1;
    end
    chk("rand_sent", sent, 10000);
    chk("rand_count", n_out, 10000);
    chk("rand_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
    $finish;
  end
endmodule
